rc4_encryption_core: RTL and testbench
======================================

// Module: rc4_encryption_core
// PURPOSE
//  RC4 encryptor; the transmit-side counterpart of the brute-force decryption cores.
//  For a 24-bit key it runs the full sequence: S init, KSA shuffle, then PRGA over MSG_DEP bytes.
//  Plaintext is read from a RAM, XORed with the keystream, and the ciphertext is written into
//  the encrypted-message ROM/RAM image that the decryption cores consume.
//  Owns the S-memory port for the whole run; an external arbiter grants S to it while busy=1.
// PARAMETERS
//  MSG_DEP     32  message length in bytes (1..256)
//  KEY_LENGTH  3   key bytes; key[0]=secret_key[23:16], key[2]=secret_key[7:0]
//  DROP_BYTES  0   keystream bytes discarded before use (only with RC4_DROP_EN)
// PORTS
//  clk         in   1   system clock
//  reset       in   1   asynchronous, active-low reset
//  start       in   1   one-cycle pulse; sampled only in IDLE
//  secret_key  in   24  key, sampled on accepted start
//  busy        out  1   high from accepted start until done
//  done        out  1   level; high after last ciphertext write, cleared on next accepted start
//  s_address   out  8   S RAM address
//  s_data      out  8   S RAM write data
//  s_wren      out  1   S RAM write enable
//  s_q         in   8   S RAM read data, valid 1 clk after address (registered read)
//  pt_address  out  8   plaintext RAM address
//  pt_q        in   8   plaintext data, valid 1 clk after address
//  ct_address  out  8   ciphertext RAM address
//  ct_data     out  8   ciphertext byte
//  ct_wren     out  1   ciphertext write enable, one cycle per byte
// BEHAVIOUR
//  Reset (async, reset==0): every output 0, state IDLE, i=j=k=0. Reset mid-run aborts the run;
//   S/ct contents are then undefined. No ct_wren is issued after reset assertion.
//  All arithmetic is 8-bit modulo 256; i wraps 255->0 and ends the phase.
//  IDLE: start=1 -> latch key, busy=1, done=0 -> INIT. start while busy is ignored.
//  INIT: s[i]=i for i=0..255, one write per clk (256 clks) -> KSA, i=0, j=0.
//  KSA, per i: RD_I (addr i) -> WAIT -> j+=s[i]+key[i%KEY_LENGTH]; RD_J -> WAIT ->
//   WR_I (s[i]=s[j]) -> WR_J (s[j]=old s[i]). Exactly 6 clks per i. After i=255 -> PRGA, i=j=k=0.
//  PRGA, per k: i=i+1; RD_I/WAIT; j+=s[i]; RD_J/WAIT; WR_I/WR_J swap;
//   RD_F (addr s[i]+s[j], pt_address=k) -> WAIT -> ct_data=s_q^pt_q, ct_address=k, ct_wren=1.
//   Exactly 9 clks per k. After k=MSG_DEP-1 -> DONE.
//  DONE: busy=0, done=1 (1 clk after the last ct_wren); -> IDLE with done held high.
//  Swap with i==j: both writes go to the same address; the net result is s[i] unchanged.
//  s_wren and ct_wren are never asserted in the same clk. s_wren is 0 outside the INIT/WR states.
//  Total latency start->done = 1 + 256 + 1536 + 9*MSG_DEP + 1 clks.
// CONFIGURATION
//  RC4_DROP_EN defined: PRGA first runs DROP_BYTES steps that perform the swaps but skip the
//   RD_F/ct write, taking 6 clks per step; k counts only emitted bytes.
//  RC4_DROP_EN undefined: DROP_BYTES is ignored; plain RC4, timing as above.
// STRUCTURE
//  rc4_pkg: state enum (IDLE, INIT, KSA_*, PRGA_*, DONE), S_DEP=256, key_byte() helper.
//  Sub-module rc4_swap_step: read-i/read-j/swap sequencer with its own start/done.
//   KSA and PRGA share it; j_increment is supplied as an input.
//  Top holds the phase FSM, i/j/k counters and the S/pt/ct port muxing.
// TESTING
//  key=0x4B6579 ("Key"), MSG_DEP=9, pt="Plaintext" -> ct=BB F3 16 E8 D9 40 AF 0A D3.
//  key=0x000000, pt all 0x00 -> ct equals C-model keystream; done exactly at computed latency.
//  Back-to-back: second start while busy=1 is ignored; start after done clears done, reruns.
//  reset pulled low during KSA at i=100 -> outputs 0 next clk; fresh start then gives correct ct.
//  Key whose KSA hits i==j (C model search) -> ct still matches the model.
//  RC4_DROP_EN, DROP_BYTES=256 -> ct matches RC4-drop256 model; latency +6*256 clks.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types for the RC4 encryption core: phase and swap-sequencer states,
// S-box depth and the key byte selector.
package rc4_pkg;

  localparam int unsigned S_DEP = 256;

  typedef enum logic [2:0] {
    IDLE, INIT, KSA_SWAP, PRGA_SWAP, PRGA_RD_F, PRGA_WAIT, PRGA_CT, DONE
  } rc4_state_e;

  typedef enum logic [2:0] {
    SW_IDLE, SW_RD_I, SW_WAIT_I, SW_RD_J, SW_WAIT_J, SW_WR_I, SW_WR_J
  } swap_state_e;

  // key[0] is the most significant byte of the 24-bit key.
  function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [7:0] idx,
                                          input int unsigned key_len);
    int unsigned sel;
    sel = 32'(idx) % key_len;
    case (sel)
      0:       return key[23:16];
      1:       return key[15:8];
      default: return key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/rc4_swap_step.sv
// One RC4 swap step: read s[i], j += s[i] + j_inc, read s[j], write both back swapped.
// Six clocks per step; a start seen in the last clock chains the next step with no bubble.
module rc4_swap_step
  import rc4_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  i_in,
  input  logic [7:0]  j_in,
  input  logic [7:0]  j_inc,
  input  logic [7:0]  s_q,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  output logic        s_wren,
  output logic [7:0]  j_out,
  output logic [7:0]  si_out,
  output logic [7:0]  sj_out,
  output logic        done,
  output swap_state_e state_dbg
);

  swap_state_e state, state_nx;
  logic [7:0]  i_r, j_r, inc_r, si_r, sj_r;
  logic        accept;

  assign accept    = start && (state == SW_IDLE || state == SW_WR_J);
  assign j_out     = j_r;
  assign si_out    = si_r;
  assign sj_out    = sj_r;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SW_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_r   <= '0;
      j_r   <= '0;
      inc_r <= '0;
      si_r  <= '0;
      sj_r  <= '0;
    end else begin
      if (accept) begin
        i_r   <= i_in;
        j_r   <= j_in;
        inc_r <= j_inc;
      end
      if (state == SW_WAIT_I) begin
        si_r <= s_q;
        j_r  <= j_r + s_q + inc_r;
      end
      if (state == SW_WAIT_J) sj_r <= s_q;
    end
  end

  // With i == j the second read returns s[i], so both writes store the same byte.
  always_comb begin
    state_nx  = state;
    s_address = '0;
    s_data    = '0;
    s_wren    = 1'b0;
    done      = 1'b0;
    case (state)
      SW_IDLE:   if (start) state_nx = SW_RD_I;
      SW_RD_I:   begin s_address = i_r; state_nx = SW_WAIT_I; end
      SW_WAIT_I: state_nx = SW_RD_J;
      SW_RD_J:   begin s_address = j_r; state_nx = SW_WAIT_J; end
      SW_WAIT_J: state_nx = SW_WR_I;
      SW_WR_I: begin
        s_address = i_r;
        s_data    = sj_r;
        s_wren    = 1'b1;
        state_nx  = SW_WR_J;
      end
      SW_WR_J: begin
        s_address = j_r;
        s_data    = si_r;
        s_wren    = 1'b1;
        done      = 1'b1;
        state_nx  = start ? SW_RD_I : SW_IDLE;
      end
      default:   state_nx = SW_IDLE;
    endcase
  end

endmodule

// File: rtl/rc4_encryption_core.sv
// RC4 encryptor: S init, KSA, PRGA with plaintext XOR into the ciphertext image.
// Optional keystream drop of DROP_BYTES bytes when RC4_DROP_EN is defined.
module rc4_encryption_core
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_DEP    = 32,
  parameter int unsigned KEY_LENGTH = 3,
  parameter int unsigned DROP_BYTES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] secret_key,
  output logic        busy,
  output logic        done,
  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  output logic        s_wren,
  input  logic [7:0]  s_q,
  output logic [7:0]  pt_address,
  input  logic [7:0]  pt_q,
  output logic [7:0]  ct_address,
  output logic [7:0]  ct_data,
  output logic        ct_wren,
  output rc4_state_e  state_dbg,
  output swap_state_e step_state_dbg
);

`ifdef RC4_DROP_EN
  localparam int unsigned DROP_STEPS = DROP_BYTES;
`else
  localparam int unsigned DROP_STEPS = 0;
`endif
  localparam int unsigned DW       = $clog2(DROP_BYTES + 2);
  localparam logic [DW-1:0] DROP_LIM = DW'(DROP_STEPS);
  localparam logic [7:0] LAST_I    = 8'(S_DEP - 1);
  localparam logic [7:0] LAST_K    = 8'(MSG_DEP - 1);

  rc4_state_e    state, state_nx;
  logic [7:0]    i, j, k, ct_byte;
  logic [23:0]   key_r;
  logic [DW-1:0] drop_cnt;

  logic       step_start, step_done, step_wren;
  logic [7:0] step_i, step_j, step_inc, step_addr, step_data;
  logic [7:0] step_j_out, step_si, step_sj;

  assign state_dbg = state;

  rc4_swap_step u_swap (
    .clk       (clk),
    .reset     (reset),
    .start     (step_start),
    .i_in      (step_i),
    .j_in      (step_j),
    .j_inc     (step_inc),
    .s_q       (s_q),
    .s_address (step_addr),
    .s_data    (step_data),
    .s_wren    (step_wren),
    .j_out     (step_j_out),
    .si_out    (step_si),
    .sj_out    (step_sj),
    .done      (step_done),
    .state_dbg (step_state_dbg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Each swap step is launched in the clock that ends the previous phase step,
  // so step_i/step_j/step_inc describe the step about to begin.
  always_comb begin
    state_nx   = state;
    step_start = 1'b0;
    step_i     = i + 8'd1;
    step_j     = step_j_out;
    step_inc   = 8'd0;
    s_address  = '0;
    s_data     = '0;
    s_wren     = 1'b0;
    pt_address = '0;
    ct_address = '0;
    ct_data    = '0;
    ct_wren    = 1'b0;
    case (state)
      IDLE: if (start) state_nx = INIT;
      INIT: begin
        s_address = i;
        s_data    = i;
        s_wren    = 1'b1;
        if (i == LAST_I) begin
          state_nx   = KSA_SWAP;
          step_start = 1'b1;
          step_j     = 8'd0;
          step_inc   = key_byte(key_r, step_i, KEY_LENGTH);
        end
      end
      KSA_SWAP: begin
        s_address = step_addr;
        s_data    = step_data;
        s_wren    = step_wren;
        if (step_done) begin
          step_start = 1'b1;
          if (i == LAST_I) begin
            state_nx = PRGA_SWAP;
            step_i   = 8'd1;
            step_j   = 8'd0;
          end else begin
            step_inc = key_byte(key_r, step_i, KEY_LENGTH);
          end
        end
      end
      PRGA_SWAP: begin
        s_address = step_addr;
        s_data    = step_data;
        s_wren    = step_wren;
        if (step_done) begin
          if (drop_cnt != DROP_LIM) step_start = 1'b1;
          else                      state_nx   = PRGA_RD_F;
        end
      end
      PRGA_RD_F: begin
        s_address  = step_si + step_sj;
        pt_address = k;
        state_nx   = PRGA_WAIT;
      end
      PRGA_WAIT: state_nx = PRGA_CT;
      PRGA_CT: begin
        ct_address = k;
        ct_data    = ct_byte;
        ct_wren    = 1'b1;
        if (k == LAST_K) begin
          state_nx = DONE;
        end else begin
          state_nx   = PRGA_SWAP;
          step_start = 1'b1;
          step_j     = j;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i        <= '0;
      j        <= '0;
      k        <= '0;
      key_r    <= '0;
      ct_byte  <= '0;
      drop_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        key_r <= secret_key;
        busy  <= 1'b1;
        done  <= 1'b0;
        i     <= '0;
        j     <= '0;
        k     <= '0;
      end
      if (state == INIT || step_start) i <= step_i;
      if ((state == KSA_SWAP || state == PRGA_SWAP) && step_done) j <= step_j_out;
      if (state == KSA_SWAP && step_done && i == LAST_I) begin
        j        <= '0;
        k        <= '0;
        drop_cnt <= '0;
      end
      if (state == PRGA_SWAP && step_done && drop_cnt != DROP_LIM) drop_cnt <= drop_cnt + DW'(1);
      if (state == PRGA_WAIT) ct_byte <= s_q ^ pt_q;
      if (state == PRGA_CT) begin
        if (k == LAST_K) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          k <= k + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rc4_encryption_core.sv
// Scoreboard bench for rc4_encryption_core with behavioural S/plaintext RAMs.
// Known RC4 vectors for the plain build; a reference model covers the drop build.
module tb_rc4_encryption_core;
  import rc4_pkg::*;

  localparam int M = 9;
`ifdef RC4_DROP_EN
  localparam int DROP = 256;
`else
  localparam int DROP = 0;
`endif
  // Inclusive count: the start clock through the first clock with done high.
  localparam int LAT_TOTAL = 1 + 256 + 1536 + 9 * M + 1 + 6 * DROP;
  localparam int LIMIT     = LAT_TOTAL + 200;

  typedef logic [7:0] msg_t [M];

  logic        clk, reset, start, busy, done, s_wren, ct_wren;
  logic [23:0] secret_key;
  logic [7:0]  s_address, s_data, s_q, pt_address, pt_q, ct_address, ct_data;
  rc4_state_e  state_dbg;
  swap_state_e step_state_dbg;

  logic [7:0]  s_mem  [256];
  logic [7:0]  pt_mem [256];
  logic [15:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  rc4_encryption_core #(.MSG_DEP(M), .KEY_LENGTH(3), .DROP_BYTES(DROP)) dut (
    .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
    .busy(busy), .done(done), .s_address(s_address), .s_data(s_data),
    .s_wren(s_wren), .s_q(s_q), .pt_address(pt_address), .pt_q(pt_q),
    .ct_address(ct_address), .ct_data(ct_data), .ct_wren(ct_wren),
    .state_dbg(state_dbg), .step_state_dbg(step_state_dbg)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Registered-read RAMs: data appears one clock after the address.
  always @(posedge clk) begin
    if (s_wren) s_mem[s_address] <= s_data;
    s_q  <= s_mem[s_address];
    pt_q <= pt_mem[pt_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---- monitor: every ciphertext write pops one expected {address, byte} ----
  always @(negedge clk) begin
    if (ct_wren) begin
      check("wren_exclusive", {31'd0, s_wren}, 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ct_unexpected: got addr %0h data %0h expected no write", ct_address, ct_data);
      end else begin
        check("ct_write", {16'd0, ct_address, ct_data}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // ---- reference model ----
  function automatic msg_t rc4_model(input logic [23:0] key, input msg_t pt);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] i, j, t;
    msg_t       ct;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      j = j + s[n] + kb[n % 3];
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 8'd0;
    j = 8'd0;
    for (int n = 0; n < DROP + M; n++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      t = s[i] + s[j];
      if (n >= DROP) ct[n - DROP] = pt[n - DROP] ^ s[t];
    end
    return ct;
  endfunction

  function automatic msg_t pick_exp(input logic [23:0] key, input msg_t pt, input msg_t hand);
`ifdef RC4_DROP_EN
    return rc4_model(key, pt);
`else
    return (key === key) ? hand : rc4_model(key, pt);
`endif
  endfunction

  // ---- drivers ----
  task automatic check_quiet(input string tag);
    check({tag, "_busy"},    {31'd0, busy},    32'd0);
    check({tag, "_s_wren"},  {31'd0, s_wren},  32'd0);
    check({tag, "_ct_wren"}, {31'd0, ct_wren}, 32'd0);
    check({tag, "_s_bus"},   {16'd0, s_address, s_data}, 32'd0);
    check({tag, "_pt_addr"}, {24'd0, pt_address}, 32'd0);
    check({tag, "_ct_bus"},  {16'd0, ct_address, ct_data}, 32'd0);
    check({tag, "_state"},   {29'd0, state_dbg}, {29'd0, IDLE});
  endtask

  task automatic pulse_start(input logic [23:0] key);
    @(negedge clk);
    secret_key = key;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    secret_key = ~key;
  endtask

  task automatic run_msg(input string name, input logic [23:0] key, input msg_t pt,
                         input msg_t exp, input bit poke_busy);
    int n;
    int poke_at;
    for (int a = 0; a < M; a++) begin
      pt_mem[a] = pt[a];
      exp_q.push_back({8'(a), exp[a]});
    end
    poke_at = $urandom_range(600, 30);
    pulse_start(key);
    @(negedge clk);
    check({name, "_busy_set"},   {31'd0, busy}, 32'd1);
    check({name, "_done_clear"}, {31'd0, done}, 32'd0);
    n = 0;
    while (!done && n < LIMIT) begin
      if (poke_busy) begin
        start      = (n == poke_at);
        secret_key = 24'hA5A5A5;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    check({name, "_latency"}, n, LAT_TOTAL - 2);
    check({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    check({name, "_all_ct"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check({name, "_done_held"}, {31'd0, done}, 32'd1);
  endtask

  // ---- stimulus ----
  msg_t pt_text, ct_text, zeros, ks_zero, ramp, expv;

  initial begin
    pt_text = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    ct_text = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    ks_zero = '{8'hDE, 8'h18, 8'h89, 8'h41, 8'hA3, 8'h37, 8'h5D, 8'h3A, 8'h8A};
    for (int a = 0; a < M; a++) begin
      zeros[a] = 8'h00;
      ramp[a]  = 8'(a * 17 + 3);
    end
    for (int a = 0; a < 256; a++) pt_mem[a] = 8'($urandom_range(255, 0));

    reset      = 1'b0;
    start      = 1'b0;
    secret_key = 24'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b1;

    // "Key" / "Plaintext", with a stray start pulse while busy
    expv = pick_exp(24'h4B6579, pt_text, ct_text);
    run_msg("key_text", 24'h4B6579, pt_text, expv, 1'b1);

    // zero key: KSA already swaps with i == j at i = 0; keystream equals ct
    expv = pick_exp(24'h000000, zeros, ks_zero);
    run_msg("zero_key", 24'h000000, zeros, expv, 1'b0);

    expv = rc4_model(24'hFFFFFF, ramp);
    run_msg("ff_key", 24'hFFFFFF, ramp, expv, 1'b0);

    // reset while KSA is on i = 100
    pulse_start(24'h4B6579);
    repeat (256 + 6 * 100) @(posedge clk);
    #2;
    check("ksa100_state", {29'd0, state_dbg}, {29'd0, KSA_SWAP});
    check("ksa100_step",  {29'd0, step_state_dbg}, {29'd0, SW_RD_I});
    reset = 1'b0;
    #1;
    check_quiet("async_rst");
    @(negedge clk);
    check_quiet("rst_next_clk");
    check("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2200) @(negedge clk);
    check("post_rst_idle", {31'd0, busy | done}, 32'd0);

    expv = pick_exp(24'h4B6579, pt_text, ct_text);
    run_msg("after_rst", 24'h4B6579, pt_text, expv, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
